// File: rtl/vreg_wb_arbiter_if.sv
// rtl/vreg_wb_arbiter_if.sv - requester, reservation, hazard and register-file write signals of the writeback arbiter
interface vreg_wb_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int DW    = 256
);
    logic [N_REQ-1:0]    REQ_VALID;
    logic [5*N_REQ-1:0]  REQ_ADDR;
    logic [DW*N_REQ-1:0] REQ_DATA;
    logic [N_REQ-1:0]    REQ_READY;
    logic                RSV_VALID;
    logic [4:0]          RSV_ADDR;
    logic                RSV_READY;
    logic [4:0]          A1;
    logic [4:0]          A2;
    logic                HAZ1;
    logic                HAZ2;
    logic                WE;
    logic [4:0]          A3;
    logic [DW-1:0]       WB;
    logic                ERR;

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA, RSV_VALID, RSV_ADDR, A1, A2,
        input  REQ_READY, RSV_READY, HAZ1, HAZ2, WE, A3, WB, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, RSV_VALID, RSV_ADDR, A1, A2,
        output REQ_READY, RSV_READY, HAZ1, HAZ2, WE, A3, WB, ERR
    );
endinterface

// File: rtl/vreg_wb_arbiter.sv
// rtl/vreg_wb_arbiter.sv - round-robin arbiter for the vector register-file write port with pending-write scoreboard
module vreg_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int NREG  = 4,
    parameter int DW    = 256,
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    vreg_wb_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREG);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    cand;
    logic             gnt_found;
    logic             hs;
    logic [N_REQ-1:0] grant;

    logic [4:0]       req_addr [N_REQ];
    logic [DW-1:0]    req_data [N_REQ];
    logic [4:0]       g_addr;
    logic [DW-1:0]    g_data;

    logic [CNT_W-1:0] cnt [NREG];
    logic [IW-1:0]    rsv_idx;
    logic [IW-1:0]    dec_idx;
    logic             rsv_ready;
    logic             inc;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;

    logic             we_q;
    logic [4:0]       a3_q;
    logic [DW-1:0]    wb_q;
    logic             err_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_addr[gi] = bus.REQ_ADDR[5*gi +: 5];
            assign req_data[gi] = bus.REQ_DATA[DW*gi +: DW];
        end
    endgenerate

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!gnt_found && bus.REQ_VALID[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign hs = gnt_found & ~RST;

    always_comb begin
        grant = '0;
        if (hs) grant[gnt_idx] = 1'b1;
    end

    assign g_addr  = req_addr[gnt_idx];
    assign g_data  = req_data[gnt_idx];

    assign rsv_idx   = bus.RSV_ADDR[IW-1:0];
    assign dec_idx   = g_addr[IW-1:0];
    assign rsv_ready = ~RST & (cnt[rsv_idx] != CNT_MAX);
    assign inc       = bus.RSV_VALID & rsv_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_vec[r] = inc & (rsv_idx == IW'(r));
            dec_vec[r] = hs & (dec_idx == IW'(r));
        end
    end

    // A same-cycle reserve and commit on one register cancel, including at count 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q   <= 1'b0;
            a3_q   <= '0;
            wb_q   <= '0;
            err_q  <= 1'b0;
            rr_ptr <= PW'(N_REQ - 1);
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            we_q <= hs;
            if (hs) begin
                a3_q   <= g_addr;
                wb_q   <= g_data;
                rr_ptr <= gnt_idx;
            end
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
                    else              err_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.REQ_READY = grant;
    assign bus.RSV_READY = rsv_ready;
    assign bus.HAZ1      = (cnt[bus.A1[IW-1:0]] != '0);
    assign bus.HAZ2      = (cnt[bus.A2[IW-1:0]] != '0);
    assign bus.WE        = we_q;
    assign bus.A3        = a3_q;
    assign bus.WB        = wb_q;
    assign bus.ERR       = err_q;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.RSV_ADDR[4:IW], bus.A1[4:IW], bus.A2[4:IW]};
endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// tb/tb_vreg_wb_arbiter.sv - self-checking bench for vreg_wb_arbiter
module tb_vreg_wb_arbiter;
    localparam int N_REQ = 3;
    localparam int NREG  = 4;
    localparam int DW    = 256;
    localparam int CMAX  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vreg_wb_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    vreg_wb_arbiter #(.N_REQ(N_REQ), .NREG(NREG), .DW(DW), .CNT_W(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int            m_cnt [NREG];
    int            m_rr;
    bit            m_err;
    bit            m_we;
    logic [4:0]    m_a3;
    logic [DW-1:0] m_wb;

    typedef struct {
        logic       rst;
        logic [2:0] vld;
        logic [4:0] ad0, ad1, ad2;
        logic       rv;
        logic [4:0] ra, a1, a2;
        logic [2:0] e_rdy;
        logic       e_rsv, e_h1, e_h2, e_we;
        logic [4:0] e_a3;
        logic       e_err;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_rr  = N_REQ - 1;
        m_err = 0;
        m_we  = 0;
        m_a3  = '0;
        m_wb  = '0;
    endtask

    function automatic int m_grant();
        if (rst) return -1;
        for (int k = 1; k <= N_REQ; k++) begin
            int c;
            c = (m_rr + k) % N_REQ;
            if (bus.REQ_VALID[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [4:0] addr_of(input int i);
        return bus.REQ_ADDR[5*i +: 5];
    endfunction

    task automatic model_check(input string tag);
        int g;
        logic [2:0] e_rdy;
        g = m_grant();
        e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk({tag, "_ready"}, DW'(bus.REQ_READY), DW'(e_rdy));
        chk({tag, "_rsv"},   DW'(bus.RSV_READY), DW'(!rst && m_cnt[bus.RSV_ADDR % NREG] != CMAX));
        chk({tag, "_haz"},   DW'({bus.HAZ1, bus.HAZ2}),
            DW'({m_cnt[bus.A1 % NREG] != 0, m_cnt[bus.A2 % NREG] != 0}));
        chk({tag, "_we"},    DW'(bus.WE),  DW'(m_we));
        chk({tag, "_a3"},    DW'(bus.A3),  DW'(m_a3));
        chk({tag, "_wb"},    bus.WB,       m_wb);
        chk({tag, "_err"},   DW'(bus.ERR), DW'(m_err));
    endtask

    // Net change per register; a negative result means a commit with nothing reserved.
    task automatic model_update();
        int g;
        int delta [NREG];
        if (rst) begin
            model_reset();
            return;
        end
        g = m_grant();
        for (int r = 0; r < NREG; r++) delta[r] = 0;
        if (bus.RSV_VALID && m_cnt[bus.RSV_ADDR % NREG] != CMAX) delta[bus.RSV_ADDR % NREG] += 1;
        if (g >= 0) begin
            delta[addr_of(g) % NREG] -= 1;
            m_we = 1;
            m_a3 = addr_of(g);
            m_wb = bus.REQ_DATA[DW*g +: DW];
            m_rr = g;
        end else begin
            m_we = 0;
        end
        for (int r = 0; r < NREG; r++) begin
            int n;
            n = m_cnt[r] + delta[r];
            if (n < 0) begin
                n = 0;
                m_err = 1;
            end
            m_cnt[r] = n;
        end
    endtask

    task automatic set_in(input logic r, input logic [2:0] vld, input logic [4:0] ad0, ad1, ad2,
                          input logic rv, input logic [4:0] ra, a1, a2);
        rst           = r;
        bus.REQ_VALID = vld;
        bus.REQ_ADDR  = {ad2, ad1, ad0};
        for (int j = 0; j < DW*N_REQ/32; j++) bus.REQ_DATA[32*j +: 32] = $urandom;
        bus.RSV_VALID = rv;
        bus.RSV_ADDR  = ra;
        bus.A1        = a1;
        bus.A2        = a2;
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //          rst vld  a0 a1 a2 rv ra  A1  A2  rdy rsv h1 h2 we a3 err
        tbl[0]  = '{1, 3'd7, 1, 2, 3, 0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3'd7, 1, 2, 3, 0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0};
        tbl[2]  = '{0, 3'd7, 1, 2, 3, 0, 0,  0,  0,  1,  1,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 3'd7, 1, 2, 3, 0, 0,  0,  0,  2,  1,  0, 0, 1, 1, 1};
        tbl[4]  = '{0, 3'd7, 1, 2, 3, 0, 0,  0,  0,  4,  1,  0, 0, 1, 2, 1};
        tbl[5]  = '{0, 3'd7, 1, 2, 3, 0, 0,  0,  0,  1,  1,  0, 0, 1, 3, 1};
        tbl[6]  = '{0, 3'd0, 1, 2, 3, 0, 0,  0,  0,  0,  1,  0, 0, 1, 1, 1};
        tbl[7]  = '{1, 3'd0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0, 0, 1, 1};
        tbl[8]  = '{0, 3'd0, 0, 0, 0, 1, 3,  3,  3,  0,  1,  0, 0, 0, 0, 0};
        tbl[9]  = '{0, 3'd0, 0, 0, 0, 1, 3,  3,  3,  0,  1,  1, 1, 0, 0, 0};
        tbl[10] = '{0, 3'd0, 0, 0, 0, 1, 3,  3,  3,  0,  1,  1, 1, 0, 0, 0};
        tbl[11] = '{0, 3'd0, 0, 0, 0, 1, 23, 3,  2,  0,  0,  1, 0, 0, 0, 0};
        tbl[12] = '{0, 3'd2, 0, 3, 0, 0, 23, 19, 2,  2,  0,  1, 0, 0, 0, 0};
        tbl[13] = '{0, 3'd2, 0, 3, 0, 0, 3,  3,  0,  2,  1,  1, 0, 1, 3, 0};
        tbl[14] = '{0, 3'd4, 0, 0, 3, 0, 3,  3,  0,  4,  1,  1, 0, 1, 3, 0};
        tbl[15] = '{0, 3'd0, 0, 0, 0, 0, 3,  3,  0,  0,  1,  0, 0, 1, 3, 0};
        tbl[16] = '{0, 3'd0, 0, 0, 0, 0, 3,  3,  0,  0,  1,  0, 0, 0, 3, 0};

        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].rst, tbl[i].vld, tbl[i].ad0, tbl[i].ad1, tbl[i].ad2,
                   tbl[i].rv, tbl[i].ra, tbl[i].a1, tbl[i].a2);
            sample($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_rdy", i), DW'(bus.REQ_READY), DW'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_rsv", i), DW'(bus.RSV_READY), DW'(tbl[i].e_rsv));
            chk($sformatf("tbl%0d_h1", i),  DW'(bus.HAZ1),      DW'(tbl[i].e_h1));
            chk($sformatf("tbl%0d_h2", i),  DW'(bus.HAZ2),      DW'(tbl[i].e_h2));
            chk($sformatf("tbl%0d_we", i),  DW'(bus.WE),        DW'(tbl[i].e_we));
            chk($sformatf("tbl%0d_a3", i),  DW'(bus.A3),        DW'(tbl[i].e_a3));
            chk($sformatf("tbl%0d_err", i), DW'(bus.ERR),       DW'(tbl[i].e_err));
            tick();
        end

        // Single-cycle request from requester 1: one-cycle write latency, then idle.
        set_in(0, 3'b010, 0, 2, 0, 0, 0, 0, 0);
        bus.REQ_DATA[DW*1 +: DW] = {32{8'hA5}};
        sample("lat0");
        chk("lat_ready", DW'(bus.REQ_READY), DW'(3'b010));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample("lat1");
        chk("lat_we1", DW'(bus.WE), DW'(1));
        chk("lat_a3",  DW'(bus.A3), DW'(2));
        chk("lat_wb",  bus.WB,      {32{8'hA5}});
        tick();
        sample("lat2");
        chk("lat_we0", DW'(bus.WE), DW'(0));
        tick();

        // Same-cycle reserve and commit on r1, then a commit to r0 with nothing reserved.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        sample("sim_rst");
        tick();
        set_in(0, 0, 0, 0, 0, 1, 1, 1, 0);
        sample("sim0");
        tick();
        set_in(0, 3'b001, 1, 0, 0, 1, 1, 1, 0);
        sample("sim1");
        chk("sim_ready", DW'(bus.REQ_READY), DW'(3'b001));
        chk("sim_rsv",   DW'(bus.RSV_READY), DW'(1));
        tick();
        set_in(0, 3'b001, 1, 0, 0, 0, 0, 1, 0);
        sample("sim2");
        chk("sim_cnt1_haz", DW'(bus.HAZ1), DW'(1));
        chk("sim_err0",     DW'(bus.ERR),  DW'(0));
        tick();
        set_in(0, 3'b001, 0, 0, 0, 0, 0, 1, 0);
        sample("sim3");
        chk("sim_cnt0_haz", DW'(bus.HAZ1), DW'(0));
        chk("sim_err_pre",  DW'(bus.ERR),  DW'(0));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        sample("sim4");
        chk("sim_we_r0",  DW'(bus.WE),  DW'(1));
        chk("sim_a3_r0",  DW'(bus.A3),  DW'(0));
        chk("sim_err1",   DW'(bus.ERR), DW'(1));
        tick();
        sample("sim5");
        chk("sim_err_sticky", DW'(bus.ERR), DW'(1));
        tick();

        // Reset while requester 2 is being granted.
        set_in(0, 0, 0, 0, 0, 1, 2, 2, 0);
        sample("mid0");
        tick();
        set_in(1, 3'b100, 0, 0, 2, 0, 0, 2, 0);
        sample("mid1");
        chk("mid_ready_rst", DW'(bus.REQ_READY), DW'(0));
        chk("mid_haz_pre",   DW'(bus.HAZ1),      DW'(1));
        tick();
        set_in(0, 3'b111, 0, 0, 0, 0, 0, 2, 0);
        sample("mid2");
        chk("mid_we",    DW'(bus.WE),        DW'(0));
        chk("mid_haz",   DW'(bus.HAZ1),      DW'(0));
        chk("mid_err",   DW'(bus.ERR),       DW'(0));
        chk("mid_rrptr", DW'(bus.REQ_READY), DW'(3'b001));
        tick();

        for (int i = 0; i < 800; i++) begin
            set_in(($urandom % 50) == 0, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            sample($sformatf("rnd%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
